stm32_bus_engine: RTL and testbench
===================================

STM32_BUS_ENGINE -- requirements
Module: stm32_bus_engine

Interface
REQ-001 SHALL have parameter NUM_RX, default 2, number of RX IQ channels (1..4).
REQ-002 SHALL have parameter SAMPLE_W, default 24, IQ sample width in bits (multiple of 8, 16..32).
REQ-003 SHALL have parameter PARAM_BYTES, default 24, length of the parameter block in bytes.
REQ-004 SHALL have parameter STATUS_BYTES, default 7, length of the status block in bytes.
REQ-005 SHALL have port clk_in, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset_in, input, 1 bit, the asynchronous active-high reset.
REQ-007 SHALL have port data_sync, input, 1 bit, command strobe from the MCU.
REQ-008 SHALL have port data_bus_in, input, 8 bits, bus byte from the MCU.
REQ-009 SHALL have ports data_bus_out (output, 8 bits) and data_bus_oe (output, 1 bit); the tristate buffer sits at top level.
REQ-010 SHALL have port params_out, output, PARAM_BYTES*8 bits, byte 0 in the MSBs; and params_update, output, 1 bit, commit pulse.
REQ-011 SHALL have port status_in, input, STATUS_BYTES*8 bits, byte 0 in the MSBs.
REQ-012 SHALL have ports rx_iq_data (input, NUM_RX*2*SAMPLE_W bits, channel c at {I,Q} slice c), rx_iq_valid (input, 1 bit) and rx_iq_rd (output, 1 bit, read pulse).
REQ-013 SHALL have ports tx_i and tx_q (outputs, SAMPLE_W bits each) and tx_iq_valid (output, 1 bit, pulse).
REQ-014 SHALL have port underrun, output, 1 bit, sticky RX underrun flag.

Function
REQ-015 Any edge with data_sync=1 SHALL abort the current transfer and decode data_bus_in: 0 BUS_TEST, 1 WRITE_PARAMS, 2 READ_STATUS, 3 TX_IQ, 4 RX_IQ; any other value SHALL go to IDLE.
REQ-016 States SHALL be: IDLE, TEST_RD, TEST_WR, WPARAM, RSTAT, TXIQ, RXIQ; a byte counter SHALL advance by one per clock while the engine is in a transfer state.
REQ-017 Write commands SHALL sample byte n (n=0..) on the (n+1)th edge after the command edge; read commands SHALL register byte n onto data_bus_out on the same edge.
REQ-018 data_bus_oe SHALL be 1 only in TEST_WR, RSTAT and RXIQ, and SHALL be 0 in IDLE and from the command edge onward.
REQ-019 WPARAM SHALL fill a shadow register; params_out SHALL update atomically with a one-cycle params_update pulse on the edge that samples byte PARAM_BYTES-1, then go to IDLE; an aborted write SHALL leave params_out unchanged.
REQ-020 RSTAT SHALL snapshot status_in on the command edge, emit STATUS_BYTES bytes MSB-first, then a final byte {7'b0, underrun}, clear underrun, and go to IDLE.
REQ-021 TXIQ SHALL collect 2*SAMPLE_W/8 bytes (Q MSB-first, then I), then update tx_q/tx_i and pulse tx_iq_valid for one cycle; an aborted frame SHALL produce no pulse.
REQ-022 RXIQ SHALL snapshot rx_iq_data on the command edge and on each edge that emits a frame's last byte; rx_iq_rd SHALL be high for the single cycle after each snapshot.
REQ-023 The RX frame SHALL contain channels whose bit is set in params_out byte 0 [NUM_RX-1:0], in ascending order, each as Q then I, MSB-first; an all-zero mask SHALL send channel 0 only.
REQ-024 RXIQ SHALL repeat frames without gaps until data_sync; the mask SHALL be sampled at frame start only.
REQ-025 A snapshot taken with rx_iq_valid=0 SHALL set underrun; the stale data SHALL still be sent.
REQ-026 BUS_TEST SHALL alternate TEST_RD (latch data_bus_in) and TEST_WR (drive the latched byte) until data_sync.

Reset
REQ-027 reset_in SHALL force IDLE, data_bus_oe=0, data_bus_out=0, params_out=0, params_update=0, tx_i=tx_q=0, tx_iq_valid=0, rx_iq_rd=0, underrun=0, and the counter to 0.
REQ-028 Reset asserted mid-transfer SHALL discard partial shadows; the first post-reset command SHALL behave as from cold.

Structure
REQ-029 A shared package stm32_bus_pkg SHALL hold the command codes, the state encoding and the status-byte layout.
REQ-030 The RX frame serializer (channel mask, channel/half/byte counters) SHALL be one sub-module, stm32_iq_serializer.

Verification
REQ-031 WRITE_PARAMS with bytes 0x01..0x18 -> params_out=0x0102..18 and a single params_update pulse on the 24th data edge.
REQ-032 WRITE_PARAMS aborted after 5 bytes by data_sync -> params_out unchanged and no params_update pulse.
REQ-033 RX_IQ with mask 2'b11, ch0 Q=0x123456, I=0xABCDEF -> bytes 12 34 56 AB CD EF, then ch1's 6 bytes, then rx_iq_rd pulse and a new frame.
REQ-034 RX_IQ with rx_iq_valid=0 at a snapshot, then READ_STATUS -> last status byte 0x01 and underrun cleared afterwards.
REQ-035 TX_IQ with bytes 00 00 01 FF FF FF -> tx_q=0x000001, tx_i=0xFFFFFF and one tx_iq_valid pulse.
REQ-036 reset_in asserted during RX_IQ byte 3 -> data_bus_oe=0 asynchronously, and BUS_TEST 0xA5 afterwards echoes 0xA5.

Source files
------------

// File: rtl/stm32_bus_pkg.sv
// Shared definitions for the MCU byte-bus engine: command codes, engine states,
// status-block tail layout and a channel-mask search helper.
package stm32_bus_pkg;

    localparam logic [7:0] CMD_BUS_TEST     = 8'd0;
    localparam logic [7:0] CMD_WRITE_PARAMS = 8'd1;
    localparam logic [7:0] CMD_READ_STATUS  = 8'd2;
    localparam logic [7:0] CMD_TX_IQ        = 8'd3;
    localparam logic [7:0] CMD_RX_IQ        = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TEST_RD = 3'd1,
        ST_TEST_WR = 3'd2,
        ST_WPARAM  = 3'd3,
        ST_RSTAT   = 3'd4,
        ST_TXIQ    = 3'd5,
        ST_RXIQ    = 3'd6
    } state_e;

    function automatic state_e cmd_to_state(input logic [7:0] cmd);
        state_e st;
        case (cmd)
            CMD_BUS_TEST:     st = ST_TEST_RD;
            CMD_WRITE_PARAMS: st = ST_WPARAM;
            CMD_READ_STATUS:  st = ST_RSTAT;
            CMD_TX_IQ:        st = ST_TXIQ;
            CMD_RX_IQ:        st = ST_RXIQ;
            default:          st = ST_IDLE;
        endcase
        return st;
    endfunction

    // Byte appended after the status block; bit 0 carries the underrun flag.
    function automatic logic [7:0] status_tail(input logic underrun);
        return {7'b0000000, underrun};
    endfunction

    // Lowest set channel index at or above 'from' (0 when none).
    function automatic logic [1:0] first_set_from(input logic [3:0] mask, input logic [2:0] from);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            r = (mask[i] && (i >= int'(from))) ? 2'(i) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/stm32_iq_serializer.sv
// Walks a snapshotted RX frame byte by byte: enabled channels ascending,
// each as Q then I, MSB-first. last_o flags the frame's final byte.
module stm32_iq_serializer
    import stm32_bus_pkg::*;
#(
    parameter int NUM_RX   = 2,
    parameter int SAMPLE_W = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic                         step_i,
    input  logic [NUM_RX-1:0]            mask_i,
    input  logic [NUM_RX*2*SAMPLE_W-1:0] data_i,
    output logic [7:0]                   byte_o,
    output logic                         last_o
);

    localparam int BPS = SAMPLE_W / 8;
    localparam int FW  = 2 * SAMPLE_W;

    logic [NUM_RX*FW-1:0] data_q, data_d;
    logic [3:0]           mask_q, mask_d;
    logic [1:0]           ch_q, ch_d;
    logic                 half_q, half_d;
    logic [1:0]           byte_q, byte_d;

    logic [FW-1:0]        frame_s;
    logic [SAMPLE_W-1:0]  smp_s;
    logic [7:0]           byte_s;
    logic [3:0]           m4_s;
    logic                 more_s;

    // Select the current channel/half/byte and normalise the incoming mask.
    always_comb begin
        frame_s = '0;
        for (int c = 0; c < NUM_RX; c++) begin
            frame_s = (ch_q == 2'(c)) ? data_q[c*FW +: FW] : frame_s;
        end
        smp_s  = half_q ? frame_s[FW-1:SAMPLE_W] : frame_s[SAMPLE_W-1:0];
        byte_s = 8'h00;
        for (int b = 0; b < BPS; b++) begin
            byte_s = (byte_q == 2'(b)) ? smp_s[(BPS-1-b)*8 +: 8] : byte_s;
        end
        m4_s = 4'b0000;
        m4_s[NUM_RX-1:0] = mask_i;
        if (m4_s == 4'b0000) begin
            m4_s = 4'b0001;
        end else begin
            m4_s = m4_s;
        end
        more_s = |(mask_q >> (3'(ch_q) + 3'd1));
    end

    assign byte_o = byte_s;
    assign last_o = half_q && (byte_q == 2'(BPS-1)) && !more_s;

    // Counter advance: byte within half, Q/I half, then next enabled channel.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        ch_d   = ch_q;
        half_d = half_q;
        byte_d = byte_q;
        if (load_i) begin
            data_d = data_i;
            mask_d = m4_s;
            ch_d   = first_set_from(m4_s, 3'd0);
            half_d = 1'b0;
            byte_d = 2'd0;
        end else if (step_i) begin
            if (byte_q == 2'(BPS-1)) begin
                byte_d = 2'd0;
                if (half_q) begin
                    half_d = 1'b0;
                    ch_d   = more_s ? first_set_from(mask_q, 3'(ch_q) + 3'd1)
                                    : first_set_from(mask_q, 3'd0);
                end else begin
                    half_d = 1'b1;
                end
            end else begin
                byte_d = byte_q + 2'd1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            mask_q <= 4'b0000;
            ch_q   <= 2'd0;
            half_q <= 1'b0;
            byte_q <= 2'd0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            ch_q   <= ch_d;
            half_q <= half_d;
            byte_q <= byte_d;
        end
    end

endmodule

// File: rtl/stm32_bus_engine.sv
// Byte-wide MCU bus engine: command decode, parameter write, status read,
// TX IQ collection and continuous RX IQ streaming. Tristate lives above this.
module stm32_bus_engine
    import stm32_bus_pkg::*;
#(
    parameter int NUM_RX       = 2,
    parameter int SAMPLE_W     = 24,
    parameter int PARAM_BYTES  = 24,
    parameter int STATUS_BYTES = 7
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         data_sync,
    input  logic [7:0]                   data_bus_in,
    output logic [7:0]                   data_bus_out,
    output logic                         data_bus_oe,
    output logic [PARAM_BYTES*8-1:0]     params_out,
    output logic                         params_update,
    input  logic [STATUS_BYTES*8-1:0]    status_in,
    input  logic [NUM_RX*2*SAMPLE_W-1:0] rx_iq_data,
    input  logic                         rx_iq_valid,
    output logic                         rx_iq_rd,
    output logic [SAMPLE_W-1:0]          tx_i,
    output logic [SAMPLE_W-1:0]          tx_q,
    output logic                         tx_iq_valid,
    output logic                         underrun
);

    localparam int PW  = PARAM_BYTES * 8;
    localparam int SW  = STATUS_BYTES * 8;
    localparam int FW  = 2 * SAMPLE_W;
    localparam int TXB = FW / 8;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                oe_q, oe_d;
    logic [7:0]          dout_q, dout_d;
    logic [PW-1:0]       params_q, params_d;
    logic [PW-9:0]       psh_q, psh_d;
    logic                upd_q, upd_d;
    logic [SW-1:0]       stat_q, stat_d;
    logic [FW-9:0]       txsh_q, txsh_d;
    logic [SAMPLE_W-1:0] txi_q, txi_d, txq_q, txq_d;
    logic                txv_q, txv_d;
    logic                rxrd_q, rxrd_d;
    logic                und_q, und_d;
    logic [7:0]          test_q, test_d;

    logic [7:0]          stat_byte_s;
    logic [FW-1:0]       tx_full_s;
    logic                ser_load_s, ser_step_s, ser_last_s;
    logic [7:0]          ser_byte_s;

    stm32_iq_serializer #(
        .NUM_RX   (NUM_RX),
        .SAMPLE_W (SAMPLE_W)
    ) u_ser (
        .clk_i  (clk_in),
        .rst_i  (reset_in),
        .load_i (ser_load_s),
        .step_i (ser_step_s),
        .mask_i (params_q[PW-8 +: NUM_RX]),
        .data_i (rx_iq_data),
        .byte_o (ser_byte_s),
        .last_o (ser_last_s)
    );

    // Next-state and output decode; data_sync overrides any transfer in flight.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        oe_d       = oe_q;
        dout_d     = dout_q;
        params_d   = params_q;
        psh_d      = psh_q;
        upd_d      = 1'b0;
        stat_d     = stat_q;
        txsh_d     = txsh_q;
        txi_d      = txi_q;
        txq_d      = txq_q;
        txv_d      = 1'b0;
        rxrd_d     = 1'b0;
        und_d      = und_q;
        test_d     = test_q;
        ser_load_s = 1'b0;
        ser_step_s = 1'b0;
        tx_full_s  = {txsh_q, data_bus_in};
        stat_byte_s = 8'h00;
        for (int i = 0; i < STATUS_BYTES; i++) begin
            stat_byte_s = (cnt_q == 8'(i)) ? stat_q[(STATUS_BYTES-1-i)*8 +: 8] : stat_byte_s;
        end

        if (data_sync) begin
            state_d = cmd_to_state(data_bus_in);
            cnt_d   = 8'd0;
            oe_d    = 1'b0;
            if (data_bus_in == CMD_READ_STATUS) begin
                stat_d = status_in;
            end else begin
                stat_d = stat_q;
            end
            if (data_bus_in == CMD_RX_IQ) begin
                ser_load_s = 1'b1;
                rxrd_d     = 1'b1;
                und_d      = und_q | ~rx_iq_valid;
            end else begin
                ser_load_s = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 8'd0;
                    oe_d  = 1'b0;
                end
                ST_TEST_RD: begin
                    test_d  = data_bus_in;
                    oe_d    = 1'b0;
                    state_d = ST_TEST_WR;
                end
                ST_TEST_WR: begin
                    dout_d  = test_q;
                    oe_d    = 1'b1;
                    state_d = ST_TEST_RD;
                end
                ST_WPARAM: begin
                    oe_d  = 1'b0;
                    psh_d = {psh_q[PW-17:0], data_bus_in};
                    if (cnt_q == 8'(PARAM_BYTES-1)) begin
                        params_d = {psh_q, data_bus_in};
                        upd_d    = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = 8'd0;
                    end else begin
                        state_d = ST_WPARAM;
                    end
                end
                ST_RSTAT: begin
                    oe_d = 1'b1;
                    if (cnt_q == 8'(STATUS_BYTES)) begin
                        dout_d  = status_tail(und_q);
                        und_d   = 1'b0;
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        dout_d = stat_byte_s;
                    end
                end
                ST_TXIQ: begin
                    oe_d   = 1'b0;
                    txsh_d = tx_full_s[FW-9:0];
                    if (cnt_q == 8'(TXB-1)) begin
                        txq_d   = tx_full_s[FW-1:SAMPLE_W];
                        txi_d   = tx_full_s[SAMPLE_W-1:0];
                        txv_d   = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_TXIQ;
                    end
                end
                ST_RXIQ: begin
                    oe_d       = 1'b1;
                    dout_d     = ser_byte_s;
                    ser_step_s = 1'b1;
                    // Re-snapshot on the last byte so the next frame follows with no gap.
                    if (ser_last_s) begin
                        ser_load_s = 1'b1;
                        rxrd_d     = 1'b1;
                        und_d      = und_q | ~rx_iq_valid;
                        cnt_d      = 8'd0;
                    end else begin
                        ser_load_s = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Engine state and registered outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            oe_q     <= 1'b0;
            dout_q   <= 8'h00;
            params_q <= '0;
            psh_q    <= '0;
            upd_q    <= 1'b0;
            stat_q   <= '0;
            txsh_q   <= '0;
            txi_q    <= '0;
            txq_q    <= '0;
            txv_q    <= 1'b0;
            rxrd_q   <= 1'b0;
            und_q    <= 1'b0;
            test_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            params_q <= params_d;
            psh_q    <= psh_d;
            upd_q    <= upd_d;
            stat_q   <= stat_d;
            txsh_q   <= txsh_d;
            txi_q    <= txi_d;
            txq_q    <= txq_d;
            txv_q    <= txv_d;
            rxrd_q   <= rxrd_d;
            und_q    <= und_d;
            test_q   <= test_d;
        end
    end

    assign data_bus_out  = dout_q;
    assign data_bus_oe   = oe_q;
    assign params_out    = params_q;
    assign params_update = upd_q;
    assign tx_i          = txi_q;
    assign tx_q          = txq_q;
    assign tx_iq_valid   = txv_q;
    assign rx_iq_rd      = rxrd_q;
    assign underrun      = und_q;

endmodule

// File: tb/tb_stm32_bus_engine.sv
// Directed self-checking bench for stm32_bus_engine (default parameters).
module tb_stm32_bus_engine;

    logic         clk_in = 1'b0;
    logic         reset_in;
    logic         data_sync;
    logic [7:0]   data_bus_in;
    logic [7:0]   data_bus_out;
    logic         data_bus_oe;
    logic [191:0] params_out;
    logic         params_update;
    logic [55:0]  status_in;
    logic [95:0]  rx_iq_data;
    logic         rx_iq_valid;
    logic         rx_iq_rd;
    logic [23:0]  tx_i, tx_q;
    logic         tx_iq_valid;
    logic         underrun;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [191:0] PARAMS_A = 192'h0102030405060708090A0B0C0D0E0F101112131415161718;

    stm32_bus_engine dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .data_sync     (data_sync),
        .data_bus_in   (data_bus_in),
        .data_bus_out  (data_bus_out),
        .data_bus_oe   (data_bus_oe),
        .params_out    (params_out),
        .params_update (params_update),
        .status_in     (status_in),
        .rx_iq_data    (rx_iq_data),
        .rx_iq_valid   (rx_iq_valid),
        .rx_iq_rd      (rx_iq_rd),
        .tx_i          (tx_i),
        .tx_q          (tx_q),
        .tx_iq_valid   (tx_iq_valid),
        .underrun      (underrun)
    );

    always #5 clk_in = ~clk_in;

    // Issue a command byte; returns at the falling edge after the command edge.
    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk_in);
        data_sync   = 1'b1;
        data_bus_in = c;
        @(negedge clk_in);
        data_sync   = 1'b0;
    endtask

    task automatic load_params(input logic [7:0] b0);
        send_cmd(8'h01);
        for (int i = 0; i < 24; i++) begin
            data_bus_in = (i == 0) ? b0 : 8'h00;
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1; data_sync = 1'b0; data_bus_in = 8'h00;
        status_in = 56'h0; rx_iq_data = 96'h0; rx_iq_valid = 1'b1;
        repeat (2) @(negedge clk_in);
        tests_run++;
        if ({data_bus_oe, data_bus_out, params_update, tx_iq_valid, rx_iq_rd, underrun} !== 13'h0) begin
            tests_failed++; $display("FAIL reset_ctrl: got %h expected 0", {data_bus_oe, data_bus_out, params_update, tx_iq_valid, rx_iq_rd, underrun});
        end
        tests_run++;
        if ({params_out, tx_i, tx_q} !== 240'h0) begin
            tests_failed++; $display("FAIL reset_data: got %h expected 0", {params_out, tx_i, tx_q});
        end
        reset_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_write_params();
        send_cmd(8'h01);
        for (int i = 0; i < 24; i++) begin
            data_bus_in = 8'(i + 1);
            @(negedge clk_in);
            tests_run++;
            if (params_update !== (i == 23)) begin
                tests_failed++; $display("FAIL wp_update byte %0d: got %b expected %b", i, params_update, (i == 23));
            end
            if (i == 22) begin
                tests_run++;
                if (params_out !== 192'h0) begin
                    tests_failed++; $display("FAIL wp_atomic: got %h expected 0", params_out);
                end
            end
        end
        tests_run++;
        if (params_out !== PARAMS_A) begin
            tests_failed++; $display("FAIL wp_value: got %h expected %h", params_out, PARAMS_A);
        end
        @(negedge clk_in);
        tests_run++;
        if (params_update !== 1'b0) begin
            tests_failed++; $display("FAIL wp_pulse_len: got %b expected 0", params_update);
        end
    endtask

    task automatic test_write_abort();
        int seen;
        seen = 0;
        send_cmd(8'h01);
        for (int i = 0; i < 5; i++) begin
            data_bus_in = 8'hEE;
            @(negedge clk_in);
            seen += int'(params_update);
        end
        send_cmd(8'hFF);
        for (int i = 0; i < 25; i++) begin
            data_bus_in = 8'hEE;
            @(negedge clk_in);
            seen += int'(params_update);
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL abort_pulse: got %0d pulses expected 0", seen);
        end
        tests_run++;
        if (params_out !== PARAMS_A) begin
            tests_failed++; $display("FAIL abort_value: got %h expected %h", params_out, PARAMS_A);
        end
    endtask

    task automatic test_tx_iq();
        logic [7:0] tb [6];
        tb = '{8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        send_cmd(8'h03);
        for (int i = 0; i < 6; i++) begin
            data_bus_in = tb[i];
            @(negedge clk_in);
            tests_run++;
            if ((tx_iq_valid !== (i == 5)) || (data_bus_oe !== 1'b0)) begin
                tests_failed++; $display("FAIL tx_valid byte %0d: got v=%b oe=%b expected v=%b oe=0", i, tx_iq_valid, data_bus_oe, (i == 5));
            end
        end
        tests_run++;
        if ((tx_q !== 24'h000001) || (tx_i !== 24'hFFFFFF)) begin
            tests_failed++; $display("FAIL tx_value: got q=%h i=%h expected q=000001 i=ffffff", tx_q, tx_i);
        end
        @(negedge clk_in);
        tests_run++;
        if (tx_iq_valid !== 1'b0) begin
            tests_failed++; $display("FAIL tx_pulse_len: got %b expected 0", tx_iq_valid);
        end
    endtask

    task automatic test_rx_iq();
        logic [7:0] eb [12];
        eb = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load_params(8'h03);
        rx_iq_valid = 1'b1;
        rx_iq_data  = {24'h445566, 24'h112233, 24'hABCDEF, 24'h123456};
        send_cmd(8'h04);
        tests_run++;
        if ((rx_iq_rd !== 1'b1) || (data_bus_oe !== 1'b0)) begin
            tests_failed++; $display("FAIL rx_start: got rd=%b oe=%b expected rd=1 oe=0", rx_iq_rd, data_bus_oe);
        end
        rx_iq_data = {24'h000000, 24'h000000, 24'h000000, 24'h778899};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            tests_run++;
            if ((data_bus_out !== eb[i]) || (data_bus_oe !== 1'b1) || (rx_iq_rd !== (i == 11))) begin
                tests_failed++; $display("FAIL rx_byte %0d: got %h oe=%b rd=%b expected %h oe=1 rd=%b", i, data_bus_out, data_bus_oe, rx_iq_rd, eb[i], (i == 11));
            end
        end
        @(negedge clk_in);
        tests_run++;
        if ((data_bus_out !== 8'h77) || (rx_iq_rd !== 1'b0)) begin
            tests_failed++; $display("FAIL rx_frame2: got %h rd=%b expected 77 rd=0", data_bus_out, rx_iq_rd);
        end
    endtask

    task automatic test_rx_mask_zero();
        logic [7:0] eb [7];
        eb = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h12};
        load_params(8'h00);
        rx_iq_data = {24'h445566, 24'h112233, 24'hABCDEF, 24'h123456};
        send_cmd(8'h04);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_in);
            tests_run++;
            if ((data_bus_out !== eb[i]) || (rx_iq_rd !== (i == 5))) begin
                tests_failed++; $display("FAIL rx_mask0 byte %0d: got %h rd=%b expected %h rd=%b", i, data_bus_out, rx_iq_rd, eb[i], (i == 5));
            end
        end
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++; $display("FAIL rx_no_underrun: got %b expected 0", underrun);
        end
    endtask

    task automatic test_underrun();
        rx_iq_valid = 1'b0;
        send_cmd(8'h04);
        rx_iq_valid = 1'b1;
        tests_run++;
        if ((underrun !== 1'b1) || (rx_iq_rd !== 1'b1)) begin
            tests_failed++; $display("FAIL underrun_set: got u=%b rd=%b expected u=1 rd=1", underrun, rx_iq_rd);
        end
        @(negedge clk_in);
        tests_run++;
        if (data_bus_out !== 8'h12) begin
            tests_failed++; $display("FAIL underrun_stale: got %h expected 12", data_bus_out);
        end
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_read_status(input logic [55:0] st, input logic [7:0] tail);
        logic [7:0] eb [8];
        for (int i = 0; i < 7; i++) eb[i] = st[(6-i)*8 +: 8];
        eb[7] = tail;
        status_in = st;
        send_cmd(8'h02);
        status_in = ~st;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            tests_run++;
            if ((data_bus_out !== eb[i]) || (data_bus_oe !== 1'b1)) begin
                tests_failed++; $display("FAIL rstat byte %0d: got %h oe=%b expected %h oe=1", i, data_bus_out, data_bus_oe, eb[i]);
            end
        end
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++; $display("FAIL rstat_clear: got %b expected 0", underrun);
        end
        @(negedge clk_in);
        tests_run++;
        if (data_bus_oe !== 1'b0) begin
            tests_failed++; $display("FAIL rstat_idle_oe: got %b expected 0", data_bus_oe);
        end
    endtask

    task automatic test_reset_mid();
        send_cmd(8'h04);
        repeat (3) @(negedge clk_in);
        tests_run++;
        if (data_bus_oe !== 1'b1) begin
            tests_failed++; $display("FAIL mid_pre_oe: got %b expected 1", data_bus_oe);
        end
        #2 reset_in = 1'b1;
        #1;
        tests_run++;
        if ((data_bus_oe !== 1'b0) || (data_bus_out !== 8'h00) || (params_out !== 192'h0)) begin
            tests_failed++; $display("FAIL mid_async: got oe=%b out=%h p0=%h expected oe=0 out=00 p0=00", data_bus_oe, data_bus_out, params_out[191:184]);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
    endtask

    task automatic test_bus_test();
        send_cmd(8'h00);
        data_bus_in = 8'hA5;
        @(negedge clk_in);
        tests_run++;
        if (data_bus_oe !== 1'b0) begin
            tests_failed++; $display("FAIL bt_rd_oe: got %b expected 0", data_bus_oe);
        end
        data_bus_in = 8'h3C;
        @(negedge clk_in);
        tests_run++;
        if ((data_bus_out !== 8'hA5) || (data_bus_oe !== 1'b1)) begin
            tests_failed++; $display("FAIL bt_echo1: got %h oe=%b expected a5 oe=1", data_bus_out, data_bus_oe);
        end
        repeat (2) @(negedge clk_in);
        tests_run++;
        if ((data_bus_out !== 8'h3C) || (data_bus_oe !== 1'b1)) begin
            tests_failed++; $display("FAIL bt_echo2: got %h oe=%b expected 3c oe=1", data_bus_out, data_bus_oe);
        end
        send_cmd(8'hFF);
        tests_run++;
        if (data_bus_oe !== 1'b0) begin
            tests_failed++; $display("FAIL bt_stop_oe: got %b expected 0", data_bus_oe);
        end
    endtask

    initial begin
        test_reset();
        test_write_params();
        test_write_abort();
        test_tx_iq();
        test_rx_iq();
        test_rx_mask_zero();
        test_underrun();
        test_read_status(56'h11223344556677, 8'h01);
        test_read_status(56'hA1B2C3D4E5F607, 8'h00);
        test_reset_mid();
        test_bus_test();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
